adc_offset_to_twos_avg: RTL and testbench
=========================================

ADC_OFFSET_TO_TWOS_AVG -- requirements
Module: adc_offset_to_twos_avg

Interface
REQ-001 The block SHALL have parameter WIRE_WIDTH, default 12, giving the ADC sample width in bits.
REQ-002 The block SHALL have parameter AVG_LOG2, default 4, legal range 0..8, with block length N = 2^AVG_LOG2 samples per average.
REQ-003 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 adc_data  input  WIRE_WIDTH  ADC sample in offset binary.
REQ-007 adc_valid  input  1  adc_data qualifier, one sample per high cycle.
REQ-008 clear  input  1  synchronous restart of averaging and overrun flag.
REQ-009 sample_out  output  WIRE_WIDTH  per-sample two's-complement result.
REQ-010 sample_valid  output  1  sample_out qualifier.
REQ-011 avg_out  output  WIRE_WIDTH  two's-complement block average.
REQ-012 avg_valid  output  1  avg_out holds an unaccepted result.
REQ-013 avg_ready  input  1  consumer accepts avg_out when avg_valid is also high.
REQ-014 overrun  output  1  sticky flag: a completed average was dropped.

Function
REQ-015 Conversion SHALL invert the MSB of adc_data, leaving the other bits unchanged: 0x800->0x000, 0x000->0x800 (-2048), 0xFFF->0x7FF.
REQ-016 Stage 1 SHALL register the converted value into sample_out, and adc_valid into sample_valid: 1-cycle latency, no stalls.
REQ-017 sample_out SHALL hold its last value while sample_valid is low.
REQ-018 The accumulator SHALL be WIRE_WIDTH+AVG_LOG2 bits and SHALL add sign-extended sample_out on each sample_valid cycle; it can never overflow.
REQ-019 A sample counter of width AVG_LOG2 SHALL count accepted samples and wrap from N-1 to 0.
REQ-020 On the sample_valid cycle where the count equals N-1, the result (acc + sample) arithmetic-shifted right by AVG_LOG2 (floor toward -inf) SHALL complete, and the accumulator SHALL restart at 0.
REQ-021 Latency SHALL be 2 cycles: the last sample of a block on adc_valid at cycle n gives avg_valid=1 at cycle n+2.
REQ-022 With AVG_LOG2=0, every sample SHALL produce an average equal to itself, at latency 2.
REQ-023 The output FSM SHALL have two states, EMPTY (avg_valid=0) and FULL (avg_valid=1).
REQ-024 EMPTY->FULL SHALL occur on a completed result, which loads avg_out.
REQ-025 FULL->EMPTY SHALL occur on avg_ready=1 with no result completing that cycle.
REQ-026 In FULL, avg_ready=1 together with a completed result SHALL load the new result and stay FULL.
REQ-027 In FULL, avg_ready=0 together with a completed result SHALL drop the new result, hold avg_out unchanged and set overrun.
REQ-028 avg_out SHALL remain stable while avg_valid=1 and avg_ready=0.
REQ-029 overrun SHALL stay set until clear or reset.
REQ-030 clear SHALL zero the accumulator, counter, avg_valid and overrun next edge, discard any sample_valid sample that same cycle, and leave stage 1 unaffected.
REQ-031 clear SHALL take priority over a simultaneous completion and handshake.

Reset
REQ-032 While rst_n=0, sample_out, sample_valid, avg_out, avg_valid, overrun, the accumulator and the counter SHALL be 0 immediately, independent of clk.
REQ-033 After rst_n deasserts, the first adc_valid sample SHALL be sample 0 of a new block.
REQ-034 Reset mid-block SHALL discard the partial sum.

Verification (WIRE_WIDTH=12, AVG_LOG2=2, avg_ready=1 unless stated)
REQ-035 adc_data 0x800,0x000,0xFFF,0x7FF on consecutive valid cycles -> sample_out 0x000,0x800,0x7FF,0xFFF, each one cycle later.
REQ-036 Four samples of 0xFFF -> avg_out 0x7FF, avg_valid for 1 cycle at n+2; four samples of 0x000 -> avg_out 0x800.
REQ-037 Rounding: inputs 0x801,0x800,0x800,0x800 -> avg_out 0x000; inputs 0x7FF,0x800,0x800,0x800 -> avg_out 0xFFF (floor).
REQ-038 avg_ready=0 across two completed blocks (0x804 x4, then 0x808 x4) -> avg_out holds 0x004 and overrun=1; avg_ready=1 for one cycle -> avg_valid=0 next cycle; clear -> overrun=0.
REQ-039 clear after 2 samples, then four samples of 0x804 -> avg_out 0x004.
REQ-040 rst_n low mid-block, asynchronous to clk -> all outputs 0 before the next edge; four samples of 0x810 after release -> avg_out 0x010.

Source files
------------

// File: rtl/adc_offset_to_twos_avg.sv
// Offset-binary ADC sample to two's complement, with a block averager
// and a one-deep valid/ready output slot for the average.
module adc_offset_to_twos_avg #(
  parameter int WIRE_WIDTH = 12,
  parameter int AVG_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIRE_WIDTH-1:0] adc_data,
  input  logic                  adc_valid,
  input  logic                  clear,
  output logic [WIRE_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic [WIRE_WIDTH-1:0] avg_out,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic                  overrun
);

  localparam int W  = WIRE_WIDTH;
  localparam int AW = W + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sext;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic                 cnt_last;
  logic                 done;
  logic [W-1:0]         result;
  logic                 load_avg;
  logic                 set_ovr;

  // Stage 1: MSB flip converts offset binary to two's complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= adc_valid;
      if (adc_valid) begin
        sample_out <= {~adc_data[W-1], adc_data[W-2:0]};
      end
    end
  end

  always_comb begin
    sext     = AW'($signed(sample_out));
    sum      = acc + sext;
    cnt_last = (cnt == CNT_LAST);
    done     = sample_valid && cnt_last && !clear;
    result   = W'(sum >>> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (cnt_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A result arriving while the slot is held un-accepted is dropped.
  always_comb begin
    state_nxt = state;
    load_avg  = 1'b0;
    set_ovr   = 1'b0;
    if (clear) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (done) begin
            state_nxt = FULL;
            load_avg  = 1'b1;
          end
        end
        FULL: begin
          if (done) begin
            if (avg_ready) load_avg = 1'b1;
            else           set_ovr  = 1'b1;
          end else if (avg_ready) begin
            state_nxt = EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      avg_out <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_avg) avg_out <= result;
      if (clear)        overrun <= 1'b0;
      else if (set_ovr) overrun <= 1'b1;
    end
  end

  assign avg_valid = (state == FULL);

endmodule

// File: tb/tb_adc_offset_to_twos_avg.sv
// Scoreboard bench for adc_offset_to_twos_avg (WIRE_WIDTH=12, AVG_LOG2=2).
// Directed vectors push hand-computed results; a negedge monitor pops them.
module tb_adc_offset_to_twos_avg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        clear;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        avg_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [11:0] sq[$];
  logic [11:0] aq[$];

  adc_offset_to_twos_avg #(
    .WIRE_WIDTH(12),
    .AVG_LOG2  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .clear       (clear),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [11:0] se;
  logic [11:0] ae;

  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected: got %h, expected none", sample_out);
      end else begin
        se = sq.pop_front();
        if (sample_out !== se) begin
          errors++;
          $display("FAIL sample: got %h, expected %h", sample_out, se);
        end
      end
    end
    if (rst_n && avg_valid && avg_ready) begin
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL avg_unexpected: got %h, expected none", avg_out);
      end else begin
        ae = aq.pop_front();
        if (avg_out !== ae) begin
          errors++;
          $display("FAIL avg: got %h, expected %h", avg_out, ae);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d, input logic [11:0] e);
    adc_data  = d;
    adc_valid = 1'b1;
    sq.push_back(e);
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic send4(input logic [11:0] d, input logic [11:0] e);
    for (int i = 0; i < 4; i++) send(d, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    adc_data  = '0;
    adc_valid = 1'b0;
    clear     = 1'b0;
    avg_ready = 1'b1;
    #3;
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_overrun", overrun, 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Conversion corners; these four also form one block: (0-2048+2047-1)/4 -> -1
    aq.push_back(12'hFFF);
    send(12'h800, 12'h000);
    send(12'h000, 12'h800);
    send(12'hFFF, 12'h7FF);
    send(12'h7FF, 12'hFFF);
    repeat (3) tick();

    // Max positive block with latency and single-cycle pulse checks
    aq.push_back(12'h7FF);
    send4(12'hFFF, 12'h7FF);
    chk("lat_n1_valid", avg_valid, 0);
    tick();
    chk("lat_n2_valid", avg_valid, 1);
    chk("lat_n2_out", avg_out, 12'h7FF);
    tick();
    chk("pulse_end", avg_valid, 0);

    aq.push_back(12'h800);
    send4(12'h000, 12'h800);
    repeat (3) tick();

    // Floor rounding
    aq.push_back(12'h000);
    send(12'h801, 12'h001);
    send(12'h800, 12'h000);
    send(12'h800, 12'h000);
    send(12'h800, 12'h000);
    repeat (3) tick();
    aq.push_back(12'hFFF);
    send(12'h7FF, 12'hFFF);
    send(12'h800, 12'h000);
    send(12'h800, 12'h000);
    send(12'h800, 12'h000);
    repeat (3) tick();

    // Backpressure and overrun
    avg_ready = 1'b0;
    aq.push_back(12'h004);
    send4(12'h804, 12'h004);
    repeat (2) tick();
    chk("hold1_valid", avg_valid, 1);
    chk("hold1_out", avg_out, 12'h004);
    chk("hold1_overrun", overrun, 0);
    send4(12'h808, 12'h008);
    repeat (2) tick();
    chk("hold2_valid", avg_valid, 1);
    chk("hold2_out", avg_out, 12'h004);
    chk("hold2_overrun", overrun, 1);
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    chk("drain_valid", avg_valid, 0);
    chk("sticky_overrun", overrun, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_overrun", overrun, 0);
    avg_ready = 1'b1;

    // Clear mid-block discards the partial sum and the concurrent sample
    send(12'h900, 12'h100);
    send(12'h900, 12'h100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    aq.push_back(12'h004);
    send4(12'h804, 12'h004);
    repeat (3) tick();

    // Asynchronous reset mid-block
    send(12'h900, 12'h100);
    send(12'h900, 12'h100);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_sample_out", sample_out, 0);
    chk("arst_sample_valid", sample_valid, 0);
    chk("arst_avg_out", avg_out, 0);
    chk("arst_avg_valid", avg_valid, 0);
    chk("arst_overrun", overrun, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    aq.push_back(12'h010);
    send4(12'h810, 12'h010);
    repeat (4) tick();

    chk("sample_queue_empty", sq.size(), 0);
    chk("avg_queue_empty", aq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
